// File: rtl/cnn_pkg.sv
// +----------------------------------------------------------------------------+
// | cnn_pkg : shared types, defaults and helpers for the CNN datapath stages  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package cnn_pkg;

   localparam int DEFAULT_DATA_W = 22;

   typedef enum logic [0:0] {
      POOL_MAX = 1'b0,
      POOL_AVG = 1'b1
   } pool_mode_t;

   // Bits needed to hold 0..n-1, never less than 1.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pool_line_buf.sv
// +----------------------------------------------------------------------------+
// | pool_line_buf : one-write, async-read register array holding the         |
// | horizontal pair results of the previous (fill) row. Revision: 1.0        |
// +----------------------------------------------------------------------------+
`default_nettype none

module pool_line_buf
   import cnn_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int WIDTH = 23,
   parameter int AW    = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_addr == AW'(i))) mem[i] <= wr_data;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_addr == AW'(i)) rd_data = mem[i];
      end
   end

endmodule

`default_nettype wire

// File: rtl/maxpool_2d.sv
// +----------------------------------------------------------------------------+
// | maxpool_2d : streaming 2x2 stride-2 pooling; MAXPOOL_AVG_EN adds avg mode |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module maxpool_2d
   import cnn_pkg::*;
#(
   parameter int DATA_W  = DEFAULT_DATA_W,
   parameter int ROW_LEN = 6,
   parameter int COL_LEN = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              relu_valid,
   input  logic [DATA_W-1:0] relu_data,
`ifdef MAXPOOL_AVG_EN
   input  logic              avg_en,
`endif
   output logic              maxpool_valid,
   output logic [DATA_W-1:0] maxpool_data,
   output logic              maxpool_last
);

   localparam int XW    = clog2(ROW_LEN);
   localparam int YW    = clog2(COL_LEN);
   localparam int DEPTH = ROW_LEN / 2;
   localparam int AW    = clog2(DEPTH);
`ifdef MAXPOOL_AVG_EN
   localparam int LB_W  = DATA_W + 1;
`else
   localparam int LB_W  = DATA_W;
`endif
   localparam logic [XW-1:0] X_LAST  = XW'(ROW_LEN - 1);
   localparam logic [YW-1:0] Y_LAST  = YW'(COL_LEN - 1);
   localparam logic [0:0]    ST_FILL = 1'b0;
   localparam logic [0:0]    ST_EMIT = 1'b1;

   logic [XW-1:0]     x;
   logic [YW-1:0]     y;
   logic [0:0]        state, state_nxt;
   logic              emit;
   logic [DATA_W-1:0] pair;
   logic [DATA_W-1:0] pair_max;
   logic [LB_W-1:0]   pair_res;
   logic [LB_W-1:0]   lb_rd;
   logic [AW-1:0]     lb_addr;
   logic [DATA_W-1:0] win_max;
   logic [DATA_W-1:0] win;
   logic              x_last, y_last, win_done;

   assign x_last   = (x == X_LAST);
   assign y_last   = (y == Y_LAST);
   assign win_done = relu_valid && emit && x[0];
   assign lb_addr  = AW'(x >> 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x <= '0;
         y <= '0;
      end else if (relu_valid) begin
         if (x_last) begin
            x <= '0;
            y <= y_last ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

   // Row phase: even rows fill the line buffer, odd rows emit windows.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_FILL;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_FILL: if (relu_valid && x_last && !y[0]) state_nxt = ST_EMIT;
         ST_EMIT: if (relu_valid && x_last &&  y[0]) state_nxt = ST_FILL;
         default: state_nxt = ST_FILL;
      endcase
   end

   always_comb begin
      emit = (state == ST_EMIT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     pair <= '0;
      else if (relu_valid && !x[0]) pair <= relu_data;
   end

   assign pair_max = (pair > relu_data) ? pair : relu_data;
   assign win_max  = (pair_max > lb_rd[DATA_W-1:0]) ? pair_max : lb_rd[DATA_W-1:0];

`ifdef MAXPOOL_AVG_EN
   pool_mode_t        mode;
   logic [DATA_W+1:0] sum4;

   // Mode is frozen for a whole frame so fill and emit rows agree.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         mode <= POOL_MAX;
      else if (relu_valid && (x == '0) && (y == '0))
         mode <= avg_en ? POOL_AVG : POOL_MAX;
   end

   assign pair_res = (mode == POOL_AVG) ? ({1'b0, pair} + {1'b0, relu_data})
                                        : {1'b0, pair_max};
   assign sum4     = {1'b0, pair_res} + {1'b0, lb_rd};
   assign win      = (mode == POOL_AVG) ? sum4[DATA_W+1:2] : win_max;
`else
   assign pair_res = pair_max;
   assign win      = win_max;
`endif

   pool_line_buf #(
      .DEPTH (DEPTH),
      .WIDTH (LB_W),
      .AW    (AW)
   ) u_line_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (relu_valid && x[0] && !emit),
      .wr_addr (lb_addr),
      .wr_data (pair_res),
      .rd_addr (lb_addr),
      .rd_data (lb_rd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         maxpool_valid <= 1'b0;
         maxpool_data  <= '0;
         maxpool_last  <= 1'b0;
      end else begin
         maxpool_valid <= win_done;
         maxpool_last  <= win_done && x_last && y_last;
         if (win_done) maxpool_data <= win;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_maxpool_2d.sv
// +----------------------------------------------------------------------------+
// | tb_maxpool_2d : scoreboard bench for maxpool_2d on a 4x4 frame           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_maxpool_2d;

   localparam int DW   = 22;
   localparam int RL   = 4;
   localparam int CL   = 4;
   localparam int NPIX = RL * CL;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          relu_valid = 1'b0;
   logic [DW-1:0] relu_data = '0;
`ifdef MAXPOOL_AVG_EN
   logic          avg_en = 1'b0;
`endif
   logic          maxpool_valid;
   logic [DW-1:0] maxpool_data;
   logic          maxpool_last;

   maxpool_2d #(
      .DATA_W  (DW),
      .ROW_LEN (RL),
      .COL_LEN (CL)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .relu_valid    (relu_valid),
      .relu_data     (relu_data),
`ifdef MAXPOOL_AVG_EN
      .avg_en        (avg_en),
`endif
      .maxpool_valid (maxpool_valid),
      .maxpool_data  (maxpool_data),
      .maxpool_last  (maxpool_last)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
      int            c;
   } exp_t;

   exp_t          sb[$];
   int            tests = 0;
   int            fails = 0;
   int            n_last = 0;
   logic [DW-1:0] pix [NPIX];
   int            idx = 0;
   logic          mode_avg = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (maxpool_valid === 1'b1) begin
         if (maxpool_last === 1'b1) n_last++;
         if (sb.size() == 0) begin
            check("spurious_valid", 64'(maxpool_valid), 64'd0);
         end else begin
            e = sb.pop_front();
            check("data", 64'(maxpool_data), 64'(e.d));
            check("last", 64'(maxpool_last), 64'(e.l));
            check("latency", 64'(cyc), 64'(e.c + 1));
         end
      end
   end

   // Reference model: keeps the whole frame and pools the 2x2 window directly.
   task automatic beat(input logic [DW-1:0] d);
      int            x, y;
      logic [DW-1:0] a, b, c, q, m;
      logic [DW+1:0] s;
      exp_t          e;
      @(negedge clk);
      relu_valid = 1'b1;
      relu_data  = d;
      x = idx % RL;
      y = idx / RL;
`ifdef MAXPOOL_AVG_EN
      if (idx == 0) mode_avg = avg_en;
`endif
      pix[idx] = d;
      if ((x % 2 == 1) && (y % 2 == 1)) begin
         a = pix[(y-1)*RL + x-1];
         b = pix[(y-1)*RL + x];
         c = pix[y*RL + x-1];
         q = pix[y*RL + x];
         m = a;
         if (b > m) m = b;
         if (c > m) m = c;
         if (q > m) m = q;
         s = (DW+2)'(a) + (DW+2)'(b) + (DW+2)'(c) + (DW+2)'(q);
         e.d = mode_avg ? s[DW+1:2] : m;
         e.l = (idx == NPIX - 1);
         e.c = cyc;
         sb.push_back(e);
      end
      idx = (idx + 1) % NPIX;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         relu_valid = 1'b0;
         relu_data  = DW'($urandom);
      end
   endtask

   task automatic frame_ramp(input int gap);
      for (int i = 0; i < NPIX; i++) begin
         beat(DW'(i));
         if (gap > 0) idle(gap);
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      idle(1);
      while (sb.size() != 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      #1;
      check("drain_timeout", 64'(sb.size()), 64'd0);
      idle(2);
   endtask

   initial begin : main
      int l0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_valid", 64'(maxpool_valid), 64'd0);
      check("reset_data",  64'(maxpool_data),  64'd0);
      check("reset_last",  64'(maxpool_last),  64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Ramp back-to-back, then with relu_valid every 4th cycle.
      frame_ramp(0);
      drain();
      frame_ramp(3);
      drain();

      // Two random frames back-to-back; exactly two frame-end markers.
      l0 = n_last;
      for (int f = 0; f < 2; f++)
         for (int i = 0; i < NPIX; i++) beat(DW'($urandom));
      drain();
      check("last_count", 64'(n_last - l0), 64'd2);

      for (int i = 0; i < NPIX; i++) beat({DW{1'b1}});
      drain();

      // Random frame with random gaps.
      for (int i = 0; i < NPIX; i++) begin
         beat(DW'($urandom));
         idle($urandom_range(0, 2));
      end
      drain();

      // Reset after 6 beats discards the partial frame.
      for (int i = 0; i < 6; i++) beat(DW'(i));
      drain();
      @(negedge clk);
      rst = 1'b1;
      relu_valid = 1'b0;
      #1;
      check("midrst_valid", 64'(maxpool_valid), 64'd0);
      check("midrst_data",  64'(maxpool_data),  64'd0);
      check("midrst_last",  64'(maxpool_last),  64'd0);
      idx = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      frame_ramp(0);
      drain();

`ifdef MAXPOOL_AVG_EN
      avg_en = 1'b1;
      frame_ramp(0);
      for (int i = 0; i < NPIX; i++) beat({DW{1'b1}});
      drain();
      avg_en = 1'b0;
      for (int i = 0; i < NPIX; i++) begin
         if (i == 6) avg_en = 1'b1;
         beat(DW'(i));
      end
      frame_ramp(0);
      drain();
      for (int i = 0; i < NPIX; i++) begin
         beat(DW'($urandom));
         idle($urandom_range(0, 1));
      end
      drain();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed time %0t", $time);
      $fatal(1);
   end

endmodule

`default_nettype wire
